retire_commit_unit: RTL and testbench
=====================================

Name: retire_commit_unit

Overview:
- Parametrised N-wide in-order retire/commit stage between the ROB head window and the architectural state: arch map table, freelist, store queue/D-cache and fetch redirect.
- Generalises single-store, stateless retire in three ways:
  - up to ST_PORTS stores per cycle, each with a valid/ready D-cache handshake;
  - a registered RUN/FLUSH/HALTED control FSM with post-mispredict holdoff;
  - persistent retire and mispredict statistics counters.

Parameters:
- N, 3, retire width (ROB head slots examined per cycle).
- ST_PORTS, 2, max stores committed per cycle (1..N).
- PHYS_REGS, 64, physical register count.
- ARCH_REGS, 32, architectural register count.
- ROB_IDX_W, 5, ROB index width.
- FLUSH_HOLD, 2, cycles retirement is blocked after a mispredict (0 = none).
- CNT_W, 32, statistics counter width.

Ports:
- clock in 1 : clock.
- reset_n in 1 : asynchronous, active-low reset.
- head_valid in N : slot valid, slot 0 oldest.
- head_complete in N : slot executed.
- head_store, head_branch, head_halt, head_mispred in N each : per-slot flags; head_mispred is already resolved (direction or target mismatch).
- head_arch_rd in N*5 : destination arch register.
- head_phys_rd, head_prev_phys_rd in N*log2(PHYS_REGS) each : new and previous physical register.
- head_rob_idx in N*ROB_IDX_W : ROB index per slot.
- head_target in N*32 : resolved branch target.
- arch_snapshot_valid in 1 : reserved, tie 0.
- sq_ready_count in log2(ST_PORTS+1) : executed stores at the SQ head.
- st_req_valid out ST_PORTS, st_req_ready in ST_PORTS : D-cache store handshake per port.
- retire_count out log2(N+1) : slots retired this cycle.
- arch_we out N, arch_waddr out N*5, arch_wpreg out N*log2(PHYS_REGS) : arch map table write ports.
- free_mask out PHYS_REGS : previous physical registers freed this cycle.
- restore_mask out PHYS_REGS : freelist image for mispredict recovery.
- sq_free_count out log2(ST_PORTS+1) : SQ entries released.
- mispredict out 1, mispred_rob_idx out ROB_IDX_W, redirect_pc out 32 : flush and redirect.
- halted out 1 : halt has retired.
- retired_total out CNT_W, mispred_total out CNT_W : statistics counters.

Behaviour:
- Reset (async, reset_n=0):
  - FSM=RUN, FLUSH counter=0, both statistics counters=0.
  - Checkpoint mask = bits [PHYS_REGS-1:ARCH_REGS] set, bits [ARCH_REGS-1:0] clear.
  - All combinational outputs are qualified by reset_n and read 0 while it is low.
  - Reset mid-flush or while halted returns to RUN on the first edge after deassertion.
- Commit walk (combinational, RUN only; in FLUSH or HALTED every commit output is 0):
  - Scan slots 0..N-1. Skip slots with head_valid=0. Stop at the first slot with head_complete=0.
  - Store k (k = ordinal of this store within the cycle, starting at 0):
    - Stop the walk if k ≥ ST_PORTS or k ≥ sq_ready_count.
    - Otherwise assert st_req_valid[k]. The slot retires only if st_req_ready[k]=1; if not, stop the walk.
    - st_req_valid[k] is asserted only for the first blocked store; younger ports stay 0.
  - Retired non-branch slot with arch_rd≠0:
    - Set arch_we, arch_waddr and arch_wpreg on that slot's own lane.
    - Clear checkpoint bit phys_rd.
    - If prev_phys_rd≠0, set free_mask[prev_phys_rd] and set checkpoint bit prev_phys_rd.
  - Retired branch with head_mispred=1:
    - Assert mispredict, mispred_rob_idx=that slot's ROB index, redirect_pc=head_target.
    - Stop the walk after this slot; the branch itself is counted in retire_count.
  - Retired halt: stop the walk after this slot.
- Derived outputs:
  - retire_count = number of slots retired.
  - sq_free_count = number of store handshakes that fired (st_req_valid & st_req_ready).
  - restore_mask = next-state checkpoint, so it includes this cycle's commits.
- FSM (registered on clock):
  - RUN→FLUSH on a retired mispredict when FLUSH_HOLD>0; load the counter with FLUSH_HOLD.
  - FLUSH decrements the counter each cycle; FLUSH→RUN when the counter reaches 1.
  - RUN→HALTED when a halt retires.
  - HALTED is held until reset; the halted output is 1 in HALTED.
  - A halt and a mispredict in the same cycle cannot occur, because the walk stops at the first of the two; if the mispredicting branch is older than the halt, the halt is not retired.
- Counters:
  - retired_total += retire_count each cycle.
  - mispred_total += mispredict each cycle.
  - Both wrap modulo 2^CNT_W.

Test Plan:
- Three complete ALU ops in slots 0–2, arch_rd=1,2,3, prev_phys_rd=4,5,6 -> retire_count=3; arch_we=3'b111; free_mask bits 4,5,6 set; retired_total=3 next cycle.
- Slots 0 and 1 are stores, sq_ready_count=2, st_req_ready=2'b01 -> st_req_valid=2'b11; retire_count=1; sq_free_count=1. Then st_req_ready=2'b11 -> retire_count=2.
- Slot 1 is a mispredicted branch with rob_idx=7, target 0x100; FLUSH_HOLD=2 -> retire_count=2; mispredict=1; mispred_rob_idx=7; redirect_pc=0x100; retire_count=0 for the next 2 cycles, then normal retirement resumes.
- Halt in slot 0, slot 1 complete -> retire_count=1; halted=1 from the next cycle; retire_count stays 0 afterwards.
- reset_n pulsed low mid-FLUSH -> all outputs 0 immediately; RUN and counters=0 after release; restore_mask=initial image (bits 32–63 set).
- Slot 0 incomplete, slots 1–2 complete -> retire_count=0; arch_we=0; st_req_valid=0.

Source files
------------

// File: rtl/retire_commit_unit.sv
`timescale 1ns/1ps
// retire_commit_unit
// N-wide in-order retire/commit stage sitting between the ROB head window and
// the architectural state (arch map table, freelist, store queue / D-cache,
// fetch redirect).
//
// Each cycle the head window is walked oldest-first and a contiguous run of
// completed slots is retired. The walk stops at an incomplete slot, at a store
// that cannot be handed to the D-cache, at a mispredicted branch (inclusive),
// or at a halt (inclusive). A registered RUN/FLUSH/HALTED FSM blocks
// retirement for FLUSH_HOLD cycles after a mispredict and permanently after a
// halt (until reset). Running totals of retired slots and mispredicts are kept.
//
// Ports
//   clock, reset_n           : clock, asynchronous active-low reset
//   head_*                   : ROB head window, slot 0 oldest, packed per slot
//   arch_snapshot_valid      : reserved, tied 0
//   sq_ready_count           : executed stores waiting at the SQ head
//   st_req_valid/ready       : per-port D-cache store handshake
//   retire_count             : slots retired this cycle
//   arch_we/waddr/wpreg      : arch map table write lanes (one per slot)
//   free_mask                : previous physical registers released this cycle
//   restore_mask             : freelist image for recovery (includes this cycle)
//   sq_free_count            : SQ entries released this cycle
//   mispredict, mispred_rob_idx, redirect_pc : flush and redirect
//   halted                   : a halt has retired
//   retired_total, mispred_total : wrapping statistics counters
module retire_commit_unit #(
  parameter int N          = 3,
  parameter int ST_PORTS   = 2,
  parameter int PHYS_REGS  = 64,
  parameter int ARCH_REGS  = 32,
  parameter int ROB_IDX_W  = 5,
  parameter int FLUSH_HOLD = 2,
  parameter int CNT_W      = 32
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [N-1:0]                        head_valid,
  input  logic [N-1:0]                        head_complete,
  input  logic [N-1:0]                        head_store,
  input  logic [N-1:0]                        head_branch,
  input  logic [N-1:0]                        head_halt,
  input  logic [N-1:0]                        head_mispred,
  input  logic [N*$clog2(ARCH_REGS)-1:0]      head_arch_rd,
  input  logic [N*$clog2(PHYS_REGS)-1:0]      head_phys_rd,
  input  logic [N*$clog2(PHYS_REGS)-1:0]      head_prev_phys_rd,
  input  logic [N*ROB_IDX_W-1:0]              head_rob_idx,
  input  logic [N*32-1:0]                     head_target,
  input  logic                                arch_snapshot_valid,
  input  logic [$clog2(ST_PORTS+1)-1:0]       sq_ready_count,
  output logic [ST_PORTS-1:0]                 st_req_valid,
  input  logic [ST_PORTS-1:0]                 st_req_ready,
  output logic [$clog2(N+1)-1:0]              retire_count,
  output logic [N-1:0]                        arch_we,
  output logic [N*$clog2(ARCH_REGS)-1:0]      arch_waddr,
  output logic [N*$clog2(PHYS_REGS)-1:0]      arch_wpreg,
  output logic [PHYS_REGS-1:0]                free_mask,
  output logic [PHYS_REGS-1:0]                restore_mask,
  output logic [$clog2(ST_PORTS+1)-1:0]       sq_free_count,
  output logic                                mispredict,
  output logic [ROB_IDX_W-1:0]                mispred_rob_idx,
  output logic [31:0]                         redirect_pc,
  output logic                                halted,
  output logic [CNT_W-1:0]                    retired_total,
  output logic [CNT_W-1:0]                    mispred_total
);

  localparam int AW  = $clog2(ARCH_REGS);
  localparam int PW  = $clog2(PHYS_REGS);
  localparam int RCW = $clog2(N+1);
  localparam int SQW = $clog2(ST_PORTS+1);
  localparam int FW  = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD+1) : 1;

  // Out of reset the architectural registers map onto the low physical
  // registers, so only the upper ones are free.
  localparam logic [PHYS_REGS-1:0] CKPT_INIT =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALTED
  } state_e;

  state_e               state_q, state_d;
  logic [FW-1:0]        hold_q, hold_d;
  logic [PHYS_REGS-1:0] ckpt_q, ckpt_d;
  logic [CNT_W-1:0]     retired_q, mispred_q;

  logic                 run;
  logic                 stop;
  logic                 slot_ok;
  logic                 halt_retired;
  int                   store_ord;
  logic [RCW-1:0]       n_ret;
  logic [SQW-1:0]       n_fire;

  // Reserved input; not used by the commit logic.
  logic unused_snapshot;
  assign unused_snapshot = arch_snapshot_valid;

  // Gating with reset_n forces every commit output to 0 while reset is held.
  assign run = reset_n && (state_q == ST_RUN);

  // Commit walk over the head window, oldest slot first.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value held over and no latch is inferred.
    stop            = 1'b0;
    slot_ok         = 1'b0;
    halt_retired    = 1'b0;
    store_ord       = 0;
    n_ret           = '0;
    n_fire          = '0;
    ckpt_d          = ckpt_q;
    st_req_valid    = '0;
    arch_we         = '0;
    arch_waddr      = '0;
    arch_wpreg      = '0;
    free_mask       = '0;
    mispredict      = 1'b0;
    mispred_rob_idx = '0;
    redirect_pc     = '0;

    for (int i = 0; i < N; i++) begin
      if (run && !stop && head_valid[i]) begin
        if (!head_complete[i]) begin
          stop = 1'b1;
        end else begin
          slot_ok = 1'b1;
          if (head_store[i]) begin
            // A store needs both a free port and an executed SQ entry.
            if (store_ord >= ST_PORTS || store_ord >= int'(sq_ready_count)) begin
              slot_ok = 1'b0;
              stop    = 1'b1;
            end else begin
              for (int p = 0; p < ST_PORTS; p++) begin
                if (p == store_ord) begin
                  st_req_valid[p] = 1'b1;
                  if (!st_req_ready[p]) begin
                    slot_ok = 1'b0;
                    stop    = 1'b1;
                  end
                end
              end
              if (slot_ok) n_fire = n_fire + SQW'(1);
              store_ord = store_ord + 1;
            end
          end

          if (slot_ok) begin
            n_ret = n_ret + RCW'(1);
            if (!head_branch[i] && (head_arch_rd[i*AW +: AW] != '0)) begin
              arch_we[i]               = 1'b1;
              arch_waddr[i*AW +: AW]   = head_arch_rd[i*AW +: AW];
              arch_wpreg[i*PW +: PW]   = head_phys_rd[i*PW +: PW];
              ckpt_d[head_phys_rd[i*PW +: PW]] = 1'b0;
              if (head_prev_phys_rd[i*PW +: PW] != '0) begin
                free_mask[head_prev_phys_rd[i*PW +: PW]] = 1'b1;
                ckpt_d[head_prev_phys_rd[i*PW +: PW]]    = 1'b1;
              end
            end
            // Younger slots are on the wrong path; the branch itself retires.
            if (head_branch[i] && head_mispred[i]) begin
              mispredict      = 1'b1;
              mispred_rob_idx = head_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
              redirect_pc     = head_target[i*32 +: 32];
              stop            = 1'b1;
            end
            if (head_halt[i]) begin
              halt_retired = 1'b1;
              stop         = 1'b1;
            end
          end
        end
      end
    end
  end

  assign retire_count  = n_ret;
  assign sq_free_count = n_fire;
  assign restore_mask  = reset_n ? ckpt_d : '0;

  // Control FSM next-state.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_retired) begin
          state_d = ST_HALTED;
        end else if (mispredict && (FLUSH_HOLD > 0)) begin
          state_d = ST_FLUSH;
          hold_d  = FW'(FLUSH_HOLD);
        end
      end
      ST_FLUSH: begin
        hold_d = hold_q - FW'(1);
        if (hold_q == FW'(1)) state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      hold_q    <= '0;
      // NOTE: the checkpoint is a recovery image that must be valid from the
      // first cycle, so unlike a data array it is given an explicit reset value.
      ckpt_q    <= CKPT_INIT;
      retired_q <= '0;
      mispred_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      hold_q    <= hold_d;
      ckpt_q    <= ckpt_d;
      retired_q <= retired_q + CNT_W'(retire_count);
      mispred_q <= mispred_q + CNT_W'(mispredict);
    end
  end

  assign halted        = (state_q == ST_HALTED);
  assign retired_total = retired_q;
  assign mispred_total = mispred_q;

endmodule

// File: tb/tb_retire_commit_unit.sv
`timescale 1ns/1ps
// Self-checking bench for retire_commit_unit: directed scenarios followed by
// randomized head windows, all checked against a slot-list reference model.
module tb_retire_commit_unit;

  localparam int N  = 3;
  localparam int SP = 2;
  localparam int PR = 64;
  localparam int AR = 32;
  localparam int RW = 5;
  localparam int FH = 2;
  localparam int CW = 32;
  localparam logic [63:0] INIT_IMG = 64'hFFFF_FFFF_0000_0000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  head_valid, head_complete, head_store, head_branch, head_halt, head_mispred;
  logic [N*5-1:0]  head_arch_rd;
  logic [N*6-1:0]  head_phys_rd, head_prev_phys_rd;
  logic [N*RW-1:0] head_rob_idx;
  logic [N*32-1:0] head_target;
  logic          arch_snapshot_valid;
  logic [1:0]    sq_ready_count;
  logic [SP-1:0] st_req_valid, st_req_ready;
  logic [1:0]    retire_count;
  logic [N-1:0]  arch_we;
  logic [N*5-1:0] arch_waddr;
  logic [N*6-1:0] arch_wpreg;
  logic [PR-1:0] free_mask, restore_mask;
  logic [1:0]    sq_free_count;
  logic          mispredict;
  logic [RW-1:0] mispred_rob_idx;
  logic [31:0]   redirect_pc;
  logic          halted;
  logic [CW-1:0] retired_total, mispred_total;

  retire_commit_unit #(
    .N(N), .ST_PORTS(SP), .PHYS_REGS(PR), .ARCH_REGS(AR),
    .ROB_IDX_W(RW), .FLUSH_HOLD(FH), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .head_valid(head_valid), .head_complete(head_complete),
    .head_store(head_store), .head_branch(head_branch),
    .head_halt(head_halt), .head_mispred(head_mispred),
    .head_arch_rd(head_arch_rd), .head_phys_rd(head_phys_rd),
    .head_prev_phys_rd(head_prev_phys_rd), .head_rob_idx(head_rob_idx),
    .head_target(head_target), .arch_snapshot_valid(arch_snapshot_valid),
    .sq_ready_count(sq_ready_count),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .retire_count(retire_count), .arch_we(arch_we),
    .arch_waddr(arch_waddr), .arch_wpreg(arch_wpreg),
    .free_mask(free_mask), .restore_mask(restore_mask),
    .sq_free_count(sq_free_count), .mispredict(mispredict),
    .mispred_rob_idx(mispred_rob_idx), .redirect_pc(redirect_pc),
    .halted(halted), .retired_total(retired_total), .mispred_total(mispred_total)
  );

  always #5 clock = ~clock;

  // Stimulus: one record per head slot.
  typedef struct {
    bit v, c, st, br, ha, mp;
    int ard, prd, pprd, rob;
    bit [31:0] tgt;
  } slot_t;

  slot_t   s[N];
  int      sq_rdy;
  bit [1:0] rdy;

  int checks = 0;
  int errors = 0;

  // Reference model state: mode 0=run, 1=flush, 2=halted.
  int       m_mode, m_hold;
  bit [63:0] m_ckpt;
  longint   m_ret, m_mis;

  // Expected outputs for the current cycle.
  int       e_rc, e_fire, e_idx;
  bit [2:0] e_we;
  int       e_waddr[N], e_wpreg[N];
  bit [63:0] e_free, e_restore;
  bit [1:0] e_stv;
  bit       e_misp, e_halt;
  bit [31:0] e_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < N; i++) begin
      s[i] = '{v:0, c:0, st:0, br:0, ha:0, mp:0, ard:0, prd:0, pprd:0, rob:0, tgt:32'h0};
    end
    sq_rdy = 0;
    rdy    = 2'b00;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      head_valid[i]    = s[i].v;
      head_complete[i] = s[i].c;
      head_store[i]    = s[i].st;
      head_branch[i]   = s[i].br;
      head_halt[i]     = s[i].ha;
      head_mispred[i]  = s[i].mp;
      head_arch_rd[i*5 +: 5]      = 5'(s[i].ard);
      head_phys_rd[i*6 +: 6]      = 6'(s[i].prd);
      head_prev_phys_rd[i*6 +: 6] = 6'(s[i].pprd);
      head_rob_idx[i*RW +: RW]    = RW'(s[i].rob);
      head_target[i*32 +: 32]     = s[i].tgt;
    end
    arch_snapshot_valid = 1'b0;
    sq_ready_count      = 2'(sq_rdy);
    st_req_ready        = rdy;
  endtask

  // Builds the list of valid slots in age order and retires from its front.
  task automatic model_eval();
    int    order[$];
    int    stores;
    slot_t x;
    e_rc = 0; e_fire = 0; e_idx = 0; e_we = '0; e_free = '0; e_stv = '0;
    e_misp = 0; e_halt = 0; e_pc = '0;
    for (int i = 0; i < N; i++) begin e_waddr[i] = 0; e_wpreg[i] = 0; end
    e_restore = m_ckpt;
    stores = 0;
    for (int i = 0; i < N; i++) if (s[i].v) order.push_back(i);
    if (m_mode == 0) begin
      for (int j = 0; j < order.size(); j++) begin
        x = s[order[j]];
        if (!x.c) break;
        if (x.st) begin
          if (stores >= SP || stores >= sq_rdy) break;
          e_stv |= 2'(1) << stores;
          if (!rdy[stores]) break;
          stores++;
          e_fire++;
        end
        e_rc++;
        if (!x.br && x.ard != 0) begin
          e_we |= 3'(1) << order[j];
          e_waddr[order[j]] = x.ard;
          e_wpreg[order[j]] = x.prd;
          e_restore &= ~(64'(1) << x.prd);
          if (x.pprd != 0) begin
            e_free    |= 64'(1) << x.pprd;
            e_restore |= 64'(1) << x.pprd;
          end
        end
        if (x.br && x.mp) begin
          e_misp = 1; e_idx = x.rob; e_pc = x.tgt;
          break;
        end
        if (x.ha) begin
          e_halt = 1;
          break;
        end
      end
    end
  endtask

  task automatic model_commit();
    m_ckpt = e_restore;
    m_ret += e_rc;
    m_mis += e_misp;
    case (m_mode)
      0: begin
        if (e_halt) m_mode = 2;
        else if (e_misp && FH > 0) begin m_mode = 1; m_hold = FH; end
      end
      1: begin
        m_hold--;
        if (m_hold == 0) m_mode = 0;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".retire_count"}, retire_count, e_rc);
    check({tag, ".arch_we"}, arch_we, e_we);
    for (int i = 0; i < N; i++) begin
      if (e_we[i]) begin
        check({tag, ".arch_waddr"}, arch_waddr[i*5 +: 5], e_waddr[i]);
        check({tag, ".arch_wpreg"}, arch_wpreg[i*6 +: 6], e_wpreg[i]);
      end
    end
    check({tag, ".free_mask"}, free_mask, e_free);
    check({tag, ".restore_mask"}, restore_mask, e_restore);
    check({tag, ".st_req_valid"}, st_req_valid, e_stv);
    check({tag, ".sq_free_count"}, sq_free_count, e_fire);
    check({tag, ".mispredict"}, mispredict, e_misp);
    if (e_misp) begin
      check({tag, ".mispred_rob_idx"}, mispred_rob_idx, e_idx);
      check({tag, ".redirect_pc"}, redirect_pc, e_pc);
    end
    check({tag, ".halted"}, halted, m_mode == 2);
    check({tag, ".retired_total"}, retired_total, 32'(m_ret));
    check({tag, ".mispred_total"}, mispred_total, 32'(m_mis));
  endtask

  // Apply inputs and compare at the falling edge.
  task automatic settle(input string tag);
    drive();
    model_eval();
    @(negedge clock);
    compare_all(tag);
  endtask

  // Let the rising edge update state; return just after it.
  task automatic advance();
    model_commit();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_seq(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, ".rst_retire_count"}, retire_count, 0);
    check({tag, ".rst_arch_we"}, arch_we, 0);
    check({tag, ".rst_free_mask"}, free_mask, 0);
    check({tag, ".rst_restore_mask"}, restore_mask, 0);
    check({tag, ".rst_st_req_valid"}, st_req_valid, 0);
    check({tag, ".rst_sq_free_count"}, sq_free_count, 0);
    check({tag, ".rst_mispredict"}, mispredict, 0);
    check({tag, ".rst_redirect_pc"}, redirect_pc, 0);
    check({tag, ".rst_halted"}, halted, 0);
    check({tag, ".rst_retired_total"}, retired_total, 0);
    check({tag, ".rst_mispred_total"}, mispred_total, 0);
    @(negedge clock);
    clear_slots();
    drive();
    #1 reset_n = 1'b1;
    m_mode = 0; m_hold = 0; m_ckpt = INIT_IMG; m_ret = 0; m_mis = 0;
    @(posedge clock);
    #1;
    check({tag, ".post_restore_mask"}, restore_mask, INIT_IMG);
    check({tag, ".post_retired_total"}, retired_total, 0);
    check({tag, ".post_halted"}, halted, 0);
    check({tag, ".post_retire_count"}, retire_count, 0);
  endtask

  task automatic alu(input int i, input int ard, input int prd, input int pprd);
    s[i] = '{v:1, c:1, st:0, br:0, ha:0, mp:0, ard:ard, prd:prd, pprd:pprd, rob:i, tgt:32'h0};
  endtask

  task automatic rand_slots();
    int k;
    for (int i = 0; i < N; i++) begin
      k = $urandom_range(0, 199);
      s[i].v    = ($urandom_range(0, 9) != 0);
      s[i].c    = ($urandom_range(0, 7) != 0);
      s[i].st   = (k >= 90 && k < 150);
      s[i].br   = (k >= 150 && k < 198);
      s[i].ha   = (k >= 198);
      s[i].mp   = s[i].br && ($urandom_range(0, 3) == 0);
      s[i].ard  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 31);
      s[i].prd  = $urandom_range(0, 63);
      s[i].pprd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 63);
      s[i].rob  = $urandom_range(0, 31);
      s[i].tgt  = $urandom;
    end
    sq_rdy = $urandom_range(0, 2);
    rdy    = 2'($urandom_range(0, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int halted_cycles;
    clear_slots();
    drive();
    reset_seq("init");

    // Three ALU ops retire together.
    clear_slots();
    alu(0, 1, 40, 4); alu(1, 2, 41, 5); alu(2, 3, 42, 6);
    settle("alu3");
    check("alu3.rc_lit", retire_count, 3);
    check("alu3.we_lit", arch_we, 3'b111);
    check("alu3.free_lit", free_mask, 64'h70);
    advance();

    // Two stores, second port not ready, then both ready.
    clear_slots();
    s[0] = '{v:1, c:1, st:1, br:0, ha:0, mp:0, ard:0, prd:0, pprd:0, rob:0, tgt:32'h0};
    s[1] = s[0];
    sq_rdy = 2; rdy = 2'b01;
    settle("st_block");
    check("st_block.total_lit", retired_total, 3);
    check("st_block.stv_lit", st_req_valid, 2'b11);
    check("st_block.rc_lit", retire_count, 1);
    check("st_block.free_lit", sq_free_count, 1);
    advance();
    rdy = 2'b11;
    settle("st_both");
    check("st_both.rc_lit", retire_count, 2);
    advance();

    // Incomplete oldest slot blocks everything behind it.
    clear_slots();
    alu(0, 9, 20, 21); s[0].c = 0;
    s[1] = '{v:1, c:1, st:1, br:0, ha:0, mp:0, ard:0, prd:0, pprd:0, rob:1, tgt:32'h0};
    alu(2, 10, 22, 23);
    sq_rdy = 2; rdy = 2'b11;
    settle("incomplete");
    check("incomplete.rc_lit", retire_count, 0);
    check("incomplete.we_lit", arch_we, 0);
    check("incomplete.stv_lit", st_req_valid, 0);
    advance();

    // Mispredicted branch in slot 1, then two blocked cycles.
    clear_slots();
    alu(0, 7, 50, 9);
    s[1] = '{v:1, c:1, st:0, br:1, ha:0, mp:1, ard:0, prd:0, pprd:0, rob:7, tgt:32'h100};
    alu(2, 8, 51, 10);
    settle("mispred");
    check("mispred.rc_lit", retire_count, 2);
    check("mispred.flag_lit", mispredict, 1);
    check("mispred.idx_lit", mispred_rob_idx, 7);
    check("mispred.pc_lit", redirect_pc, 32'h100);
    advance();
    for (int c = 0; c < FH; c++) begin
      settle("flush");
      check("flush.rc_lit", retire_count, 0);
      advance();
    end
    s[1].mp = 0;
    settle("resume");
    check("resume.rc_lit", retire_count, 3);
    advance();

    // Reset asserted while the FSM is in FLUSH.
    clear_slots();
    s[0] = '{v:1, c:1, st:0, br:1, ha:0, mp:1, ard:0, prd:0, pprd:0, rob:3, tgt:32'h200};
    settle("mis2");
    advance();
    settle("mis2_flush");
    advance();
    reset_seq("midflush");
    clear_slots();
    alu(0, 1, 33, 2);
    settle("after_rst");
    check("after_rst.rc_lit", retire_count, 1);
    advance();

    // Halt in slot 0 stops the walk and parks the FSM.
    clear_slots();
    s[0] = '{v:1, c:1, st:0, br:0, ha:1, mp:0, ard:0, prd:0, pprd:0, rob:0, tgt:32'h0};
    alu(1, 4, 34, 3);
    settle("halt");
    check("halt.rc_lit", retire_count, 1);
    advance();
    for (int c = 0; c < 3; c++) begin
      settle("halted");
      check("halted.flag_lit", halted, 1);
      check("halted.rc_lit", retire_count, 0);
      advance();
    end
    reset_seq("unhalt");

    // Randomized windows.
    halted_cycles = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ((m_mode == 2 && halted_cycles >= 3) || $urandom_range(0, 99) == 0) begin
        rand_slots();
        drive();
        reset_seq("rand_rst");
        halted_cycles = 0;
      end
      rand_slots();
      settle("rand");
      advance();
      if (m_mode == 2) halted_cycles++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
